dds_nco_iq: RTL and testbench
=============================

# dds_nco_iq

Parametrised quadrature NCO replacing the fixed-frequency DDS carrier generator. Phase accumulator with run-time tuning word and phase offset, quarter-wave sine table with quadrant folding, and simultaneous signed sine/cosine outputs. Frequency and phase updates arrive through a valid/ready config port and are applied immediately or phase-continuously at the next accumulator wrap. Sits between the modulator control logic and the mixer/DAC datapath.

## Interface
- ACC_W, 32: phase accumulator width (16..64).
- ADDR_W, 12: full-cycle phase address width (top ADDR_W accumulator bits); table holds 2^(ADDR_W-2) entries.
- DATA_W, 12: output sample width, signed two's complement.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-high (port name kept for codebase consistency).
- en  in  1  accumulator advance enable.
- cfg_valid  in  1  config word offered.
- cfg_ready  out  1  config can be accepted.
- cfg_ftw  in  ACC_W  frequency tuning word.
- cfg_pow  in  ACC_W  phase offset word.
- cfg_at_wrap  in  1  1: apply at next accumulator wrap; 0: apply next cycle.
- cfg_sync  in  1  clear accumulator when the config is applied.
- out_valid  out  1  sin_out/cos_out carry a new sample.
- sin_out  out  DATA_W  sine sample.
- cos_out  out  DATA_W  cosine sample.

## Operation
- Reset: acc, ftw, pow, pending flag, pipeline, sin_out, cos_out, out_valid all 0; cfg_ready = 1 in the cycle after reset deasserts. Reset mid-operation discards any pending config.
- Config accept: cfg_valid && cfg_ready; ftw/pow/sync/at_wrap captured into shadow registers, pending set, cfg_ready = !pending.
- Apply: at_wrap=0 → shadow copied to active registers on the cycle after accept. at_wrap=1 → copied on the first cycle with en=1 where acc + ftw (active) carries out of ACC_W; if en stays 0 the update stays pending. Apply clears pending; cfg_ready returns 1 the next cycle.
- Accumulator: en=1 → acc <= acc + ftw (mod 2^ACC_W); en=0 → hold. Apply cycle with sync=1 → acc <= 0 (overrides add). Apply with sync=0 → add uses the old ftw that cycle, new ftw from the next.
- Phase: p = (acc + pow) mod 2^ACC_W; addr = p[ACC_W-1 -: ADDR_W]; quadrant q = addr[ADDR_W-1:ADDR_W-2], index k = addr low bits.
- Table T[k] = round((2^(DATA_W-1)-1)·sin(2π(k+0.5)/2^ADDR_W)), built at elaboration; all entries positive.
- Folding, M = 2^(ADDR_W-2)-1: sin = q0:+T[k], q1:+T[M-k], q2:−T[k], q3:−T[M-k]; cos = q0:+T[M-k], q1:−T[k], q2:−T[M-k], q3:+T[k]. Never ±2^(DATA_W-1).

## Timing
- Pipeline S1 phase add and fold, S2 table read (registered), S3 negate and output register. Accumulator to sin_out/cos_out latency = 3 cycles.
- Each cycle with en=1 produces one sample; out_valid = en delayed 3 cycles. With out_valid=0 the outputs hold their last values.
- Config-to-effect: at_wrap=0 → new ftw/pow used by the accumulator/phase add 2 cycles after the accept edge; visible at outputs 3 cycles later.
- Max one pending config; a second cfg_valid waits on cfg_ready.
- Wrap with ftw=0 never occurs; at_wrap=1 update with ftw=0 active stays pending until reset.

## Configuration
- DDS_DITHER_EN defined: 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every en cycle; its top (ACC_W−ADDR_W, max 16) bits are added to the truncated phase below the address field before truncation, spreading spurs. Latency unchanged.
- Undefined: no LFSR; pure truncation; outputs bit-exact against the folding formula.

## Test plan
- Reset then ftw=2^20, pow=0, at_wrap=0, en=1 (defaults): addr increments by 1 per cycle; sin_out at addr 1023 = 2047, sin(n+2048) = −sin(n), cos(n) = sin(n+1024) for all n; period 4096 valid samples.
- pow=2^30 with ftw=0: constant sin_out = cos of pow=0 = 2047 (T[1023]), cos_out = −2 (−T[0]).
- ftw=2^28, accept new ftw=2^27 with at_wrap=1 mid-cycle: step changes only on the sample after the carry cycle; no phase discontinuity; cfg_ready low until apply.
- cfg_sync=1, at_wrap=0: acc 0 on apply, first output 3 cycles later = T[0] = 2, cos = 2047.
- en toggled 1/0 alternately: out_valid mirrors en with 3-cycle delay; held samples unchanged.
- rst_n asserted with pending config: pending dropped, outputs 0, cfg_ready 1 after release, no stale update applied.

Source files
------------

// File: rtl/dds_nco_iq.sv
`default_nettype none
// ============================================================================
// Module   : dds_nco_iq
// Summary  : Quadrature NCO. Phase accumulator with run-time tuning/offset,
//            quarter-wave sine table, signed sine/cosine outputs.
//            Optional LFSR phase dither when DDS_DITHER_EN is defined.
// Revision : 1.0
// ============================================================================

module dds_nco_iq #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ACC_W-1:0]  cfg_ftw,
    input  logic [ACC_W-1:0]  cfg_pow,
    input  logic              cfg_at_wrap,
    input  logic              cfg_sync,
    output logic              out_valid,
    output logic [DATA_W-1:0] sin_out,
    output logic [DATA_W-1:0] cos_out
);

    localparam int c_K_W   = ADDR_W - 2;
    localparam int c_DEPTH = 1 << c_K_W;
    localparam int c_MAG_W = DATA_W - 1;
    localparam int c_LO_W  = ACC_W - ADDR_W;

    // Quarter-wave entry k: round(A * sin(2*pi*(k+0.5)/2^ADDR_W)), Taylor series.
    function automatic logic [c_MAG_W-1:0] f_sine_entry(input int k);
        real x;
        real term;
        real s;
        real amp;
        x    = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(c_DEPTH * 4);
        term = x;
        s    = x;
        for (int i = 1; i < 14; i++) begin
            term = -term * x * x / real'((2 * i) * (2 * i + 1));
            s    = s + term;
        end
        amp = real'((1 << c_MAG_W) - 1) * s;
        return c_MAG_W'($rtoi(amp + 0.5));
    endfunction

    logic [c_MAG_W-1:0] rom_w [c_DEPTH];

    for (genvar g = 0; g < c_DEPTH; g++) begin : g_rom
        assign rom_w[g] = f_sine_entry(g);
    end

    // ------------------------------------------------------------------------
    // Config shadow, apply control and phase accumulator
    // ------------------------------------------------------------------------
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] ftw_q, ftw_d;
    logic [ACC_W-1:0] pow_q, pow_d;
    logic [ACC_W-1:0] sh_ftw_q, sh_ftw_d;
    logic [ACC_W-1:0] sh_pow_q, sh_pow_d;
    logic             sh_sync_q, sh_sync_d;
    logic             sh_wrap_q, sh_wrap_d;
    logic             pending_q, pending_d;
    logic [ACC_W:0]   sum_w;
    logic             accept_w;
    logic             apply_w;

    assign cfg_ready = !pending_q;

    always_comb begin
        sum_w     = {1'b0, acc_q} + {1'b0, ftw_q};
        accept_w  = cfg_valid && !pending_q;
        apply_w   = pending_q && (!sh_wrap_q || (en && sum_w[ACC_W]));
        acc_d     = acc_q;
        ftw_d     = ftw_q;
        pow_d     = pow_q;
        sh_ftw_d  = sh_ftw_q;
        sh_pow_d  = sh_pow_q;
        sh_sync_d = sh_sync_q;
        sh_wrap_d = sh_wrap_q;
        pending_d = pending_q;

        if (en) begin
            acc_d = sum_w[ACC_W-1:0];
        end
        // The add this cycle still uses the old ftw; sync overrides the add.
        if (apply_w) begin
            ftw_d     = sh_ftw_q;
            pow_d     = sh_pow_q;
            pending_d = 1'b0;
            if (sh_sync_q) begin
                acc_d = '0;
            end
        end
        if (accept_w) begin
            sh_ftw_d  = cfg_ftw;
            sh_pow_d  = cfg_pow;
            sh_sync_d = cfg_sync;
            sh_wrap_d = cfg_at_wrap;
            pending_d = 1'b1;
        end
    end

    // rst_n is an active-high synchronous reset despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            acc_q     <= '0;
            ftw_q     <= '0;
            pow_q     <= '0;
            sh_ftw_q  <= '0;
            sh_pow_q  <= '0;
            sh_sync_q <= 1'b0;
            sh_wrap_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            ftw_q     <= ftw_d;
            pow_q     <= pow_d;
            sh_ftw_q  <= sh_ftw_d;
            sh_pow_q  <= sh_pow_d;
            sh_sync_q <= sh_sync_d;
            sh_wrap_q <= sh_wrap_d;
            pending_q <= pending_d;
        end
    end

    // ------------------------------------------------------------------------
    // S1: phase add (optionally dithered) and quadrant fold
    // ------------------------------------------------------------------------
    logic [ACC_W-1:0] phase_w;

`ifdef DDS_DITHER_EN
    localparam int c_DITH_W = (c_LO_W > 16) ? 16 : c_LO_W;

    logic [15:0]      lfsr_q, lfsr_d;
    logic [ACC_W-1:0] dith_w;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
        // LFSR top bits sit directly below the address field.
        dith_w = '0;
        dith_w[c_LO_W-1 -: c_DITH_W] = lfsr_q[15 -: c_DITH_W];
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign phase_w = acc_q + pow_q + dith_w;
`else
    assign phase_w = acc_q + pow_q;
`endif

    logic [ADDR_W-1:0] addr_w;
    logic [1:0]        quad_w;
    logic [c_K_W-1:0]  k_w;

    assign addr_w = ADDR_W'(phase_w >> c_LO_W);
    assign quad_w = addr_w[ADDR_W-1 -: 2];
    assign k_w    = addr_w[c_K_W-1:0];

    logic [c_K_W-1:0] sin_idx_q, cos_idx_q;
    logic             sin_neg1_q, cos_neg1_q, v1_q;

    // ~k equals M-k for the all-ones quarter index range.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sin_idx_q  <= '0;
            cos_idx_q  <= '0;
            sin_neg1_q <= 1'b0;
            cos_neg1_q <= 1'b0;
            v1_q       <= 1'b0;
        end else begin
            sin_idx_q  <= quad_w[0] ? ~k_w : k_w;
            cos_idx_q  <= quad_w[0] ? k_w : ~k_w;
            sin_neg1_q <= quad_w[1];
            cos_neg1_q <= quad_w[1] ^ quad_w[0];
            v1_q       <= en;
        end
    end

    // ------------------------------------------------------------------------
    // S2: registered table read
    // ------------------------------------------------------------------------
    logic [c_MAG_W-1:0] sin_mag_q, cos_mag_q;
    logic               sin_neg2_q, cos_neg2_q, v2_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sin_mag_q  <= '0;
            cos_mag_q  <= '0;
            sin_neg2_q <= 1'b0;
            cos_neg2_q <= 1'b0;
            v2_q       <= 1'b0;
        end else begin
            sin_mag_q  <= rom_w[sin_idx_q];
            cos_mag_q  <= rom_w[cos_idx_q];
            sin_neg2_q <= sin_neg1_q;
            cos_neg2_q <= cos_neg1_q;
            v2_q       <= v1_q;
        end
    end

    // ------------------------------------------------------------------------
    // S3: sign restore and output register; outputs hold on invalid cycles
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] sin_ext_w, cos_ext_w;
    logic [DATA_W-1:0] sin_q, cos_q;
    logic              out_valid_q;

    assign sin_ext_w = {1'b0, sin_mag_q};
    assign cos_ext_w = {1'b0, cos_mag_q};

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sin_q       <= '0;
            cos_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                sin_q <= sin_neg2_q ? -sin_ext_w : sin_ext_w;
                cos_q <= cos_neg2_q ? -cos_ext_w : cos_ext_w;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sin_out   = sin_q;
    assign cos_out   = cos_q;

endmodule

`default_nettype wire

// File: tb/tb_dds_nco_iq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_nco_iq
// Summary  : Cycle model of dds_nco_iq with a scoreboard of expected samples.
// Revision : 1.0
// ============================================================================

module tb_dds_nco_iq;

    localparam int  ACC_W  = 32;
    localparam int  ADDR_W = 12;
    localparam int  DATA_W = 12;
    localparam real c_PI   = 3.14159265358979323846;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [ACC_W-1:0]  cfg_ftw;
    logic [ACC_W-1:0]  cfg_pow;
    logic              cfg_at_wrap;
    logic              cfg_sync;
    logic              out_valid;
    logic [DATA_W-1:0] sin_out;
    logic [DATA_W-1:0] cos_out;

    dds_nco_iq #(
        .ACC_W  (ACC_W),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ftw     (cfg_ftw),
        .cfg_pow     (cfg_pow),
        .cfg_at_wrap (cfg_at_wrap),
        .cfg_sync    (cfg_sync),
        .out_valid   (out_valid),
        .sin_out     (sin_out),
        .cos_out     (cos_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint            stamp;
        logic [DATA_W-1:0] s;
        logic [DATA_W-1:0] c;
    } exp_t;

    exp_t   sb_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;

    logic [ACC_W-1:0]  m_acc, m_ftw, m_pow, m_sh_ftw, m_sh_pow;
    logic              m_sh_sync, m_sh_wrap, m_pend;
    logic [DATA_W-1:0] hold_s, hold_c;

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Ideal rounded sample straight from sin/cos of the centred table phase.
    function automatic logic [DATA_W-1:0] ref_sample(input logic [ACC_W-1:0] ph, input bit want_cos);
        int  addr;
        real th;
        real v;
        int  mag;
        addr = int'(ph >> (ACC_W - ADDR_W));
        th   = 2.0 * c_PI * (real'(addr) + 0.5) / real'(1 << ADDR_W);
        v    = want_cos ? $cos(th) : $sin(th);
        mag  = $rtoi(((v < 0.0) ? -v : v) * real'((1 << (DATA_W - 1)) - 1) + 0.5);
        return (v < 0.0) ? DATA_W'(-mag) : DATA_W'(mag);
    endfunction

    // One clock: update the model at the rising edge, check outputs at the falling edge.
    task automatic step();
        logic [ACC_W:0]   sum;
        logic             apply;
        logic             accept;
        logic [ACC_W-1:0] ph;
        exp_t             e;
        @(posedge clk);
        if (rst_n) begin
            m_acc = '0; m_ftw = '0; m_pow = '0; m_sh_ftw = '0; m_sh_pow = '0;
            m_sh_sync = 1'b0; m_sh_wrap = 1'b0; m_pend = 1'b0;
            hold_s = '0; hold_c = '0;
            sb_q.delete();
        end else begin
            sum    = {1'b0, m_acc} + {1'b0, m_ftw};
            apply  = m_pend && (!m_sh_wrap || (en && sum[ACC_W]));
            accept = cfg_valid && !m_pend;
            if (en) begin
                ph      = m_acc + m_pow;
                e.stamp = cyc;
                e.s     = ref_sample(ph, 1'b0);
                e.c     = ref_sample(ph, 1'b1);
                sb_q.push_back(e);
                m_acc = sum[ACC_W-1:0];
            end
            if (apply) begin
                if (m_sh_sync) m_acc = '0;
                m_ftw  = m_sh_ftw;
                m_pow  = m_sh_pow;
                m_pend = 1'b0;
            end
            if (accept) begin
                m_sh_ftw  = cfg_ftw;
                m_sh_pow  = cfg_pow;
                m_sh_sync = cfg_sync;
                m_sh_wrap = cfg_at_wrap;
                m_pend    = 1'b1;
            end
        end
        cyc++;
        @(negedge clk);
        check_value("cfg_ready", cfg_ready, !m_pend);
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                check_value("out_valid_unexpected", out_valid, 1'b0);
            end else begin
                e = sb_q.pop_front();
                check_value("latency", cyc - e.stamp, 3);
                check_value("sin_out", sin_out, e.s);
                check_value("cos_out", cos_out, e.c);
                hold_s = e.s;
                hold_c = e.c;
            end
        end else begin
            check_value("sin_hold", sin_out, hold_s);
            check_value("cos_hold", cos_out, hold_c);
            if (sb_q.size() > 0 && (cyc - sb_q[0].stamp) >= 3) begin
                check_value("out_valid_missing", out_valid, 1'b1);
                void'(sb_q.pop_front());
            end
        end
    endtask

    // Offer a config and wait (bounded) for the DUT to take it.
    task automatic send_cfg(input logic [ACC_W-1:0] ftw, input logic [ACC_W-1:0] pow,
                            input logic at_wrap, input logic sync);
        logic taken;
        int   waited;
        taken       = 1'b0;
        waited      = 0;
        cfg_ftw     = ftw;
        cfg_pow     = pow;
        cfg_at_wrap = at_wrap;
        cfg_sync    = sync;
        cfg_valid   = 1'b1;
        while (!taken && waited < 200) begin
            taken = cfg_ready;
            step();
            waited++;
        end
        cfg_valid = 1'b0;
        check_value("cfg_accept_timeout", taken, 1'b1);
    endtask

    initial begin
        rst_n       = 1'b1;
        en          = 1'b0;
        cfg_valid   = 1'b0;
        cfg_ftw     = '0;
        cfg_pow     = '0;
        cfg_at_wrap = 1'b0;
        cfg_sync    = 1'b0;
        repeat (3) step();
        check_value("rst_sin", sin_out, 0);
        check_value("rst_cos", cos_out, 0);
        check_value("rst_valid", out_valid, 0);
        check_value("rst_ready", cfg_ready, 1);
        rst_n = 1'b0;
        step();

        // Full period sweep, one address step per sample.
        en = 1'b1;
        send_cfg(32'h0010_0000, '0, 1'b0, 1'b0);
        repeat (4200) step();

        // Constant phase offset of a quarter turn with ftw = 0.
        send_cfg('0, 32'h4000_0000, 1'b0, 1'b1);
        repeat (6) step();
        check_value("pow_q1_sin", sin_out, 12'd2047);
        check_value("pow_q1_cos", cos_out, 12'hFFE);

        // Synchronous clear: T[0] / T[M].
        send_cfg('0, '0, 1'b0, 1'b1);
        repeat (5) step();
        check_value("sync_sin", sin_out, 12'd2);
        check_value("sync_cos", cos_out, 12'd2047);

        // Phase-continuous change applied at the accumulator wrap.
        send_cfg(32'h1000_0000, '0, 1'b0, 1'b1);
        repeat (5) step();
        send_cfg(32'h0800_0000, '0, 1'b1, 1'b0);
        check_value("wrap_pending_ready", cfg_ready, 1'b0);
        repeat (40) step();

        // Alternating enable: out_valid follows en by three cycles, outputs hold.
        repeat (40) begin
            en = ~en;
            step();
        end

        // Random enable with sporadic configuration offers.
        repeat (400) begin
            en          = ($urandom_range(0, 3) != 0);
            cfg_valid   = ($urandom_range(0, 7) == 0);
            cfg_ftw     = $urandom() | 32'h0000_0100;
            cfg_pow     = $urandom();
            cfg_at_wrap = $urandom_range(0, 1) == 1;
            cfg_sync    = $urandom_range(0, 3) == 0;
            step();
        end
        cfg_valid = 1'b0;
        en        = 1'b1;
        repeat (6) step();

        // Mid-run reset, then a config that can never wrap and must be dropped by reset.
        rst_n = 1'b1;
        repeat (2) step();
        rst_n = 1'b0;
        step();
        send_cfg('0, '0, 1'b0, 1'b1);
        repeat (5) step();
        send_cfg(32'h0100_0000, 32'h2000_0000, 1'b1, 1'b1);
        repeat (10) step();
        check_value("stuck_pending_ready", cfg_ready, 1'b0);
        rst_n = 1'b1;
        repeat (2) step();
        check_value("rst2_sin", sin_out, 0);
        check_value("rst2_cos", cos_out, 0);
        check_value("rst2_valid", out_valid, 0);
        rst_n = 1'b0;
        step();
        check_value("rst2_ready", cfg_ready, 1'b1);
        repeat (8) step();
        check_value("no_stale_sin", sin_out, 12'd2);
        check_value("no_stale_cos", cos_out, 12'd2047);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
